// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and default widths for the add/sub function stage
// and the block accumulator that sits downstream of it.
//   accum_state_e    : accumulator FSM state (ACCUM collects, HOLD presents)
//   ADDSUB_DATA_W    : width of one add/sub result
//   ADDSUB_ACC_W     : accumulator width
//   ADDSUB_BLOCK_LEN : results summed per block
package addsub_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } accum_state_e;

  localparam int ADDSUB_DATA_W    = 4;
  localparam int ADDSUB_ACC_W     = 12;
  localparam int ADDSUB_BLOCK_LEN = 8;

endpackage : addsub_pkg

// File: rtl/addsub_accum.sv
// addsub_accum: block accumulator for the add/sub stage results.
// Sums BLOCK_LEN accepted results into an ACC_W accumulator, counts how many
// came from additions and how many from subtractions, then presents the
// totals on a valid/ready output and holds them until they are taken.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both 1. ready never depends combinationally on valid;
// here in_ready_o and out_valid_o are decoded from the state register only.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset (beats clear_i)
//   clear_i        synchronous abort of the current block (beats handshakes)
//   in_valid_i     result present
//   in_ready_o     block can accept a result (state == ACCUM)
//   in_data_i      result value, unsigned, DATA_W bits
//   in_add_i       1 = addition result, 0 = subtraction result
//   out_valid_o    block totals valid (state == HOLD)
//   out_ready_i    consumer takes totals
//   out_sum_o      sum of the block's results, modulo 2^ACC_W
//   out_add_cnt_o  number of addition results in the block
//   out_sub_cnt_o  number of subtraction results in the block
//   out_ovf_o      sticky: accumulator carried out during this block
//   dbg_state_o    current FSM state, for observation only
module addsub_accum
  import addsub_pkg::*;
#(
  parameter  int DATA_W    = ADDSUB_DATA_W,
  parameter  int ACC_W     = ADDSUB_ACC_W,
  parameter  int BLOCK_LEN = ADDSUB_BLOCK_LEN,
  localparam int CNT_W     = $clog2(BLOCK_LEN + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_add_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ACC_W-1:0]  out_sum_o,
  output logic [CNT_W-1:0]  out_add_cnt_o,
  output logic [CNT_W-1:0]  out_sub_cnt_o,
  output logic              out_ovf_o,
  output accum_state_e      dbg_state_o
);

  if (ACC_W <= DATA_W) begin : g_bad_acc_w
    $error("addsub_accum: ACC_W must be greater than DATA_W");
  end
  if (BLOCK_LEN < 2) begin : g_bad_block_len
    $error("addsub_accum: BLOCK_LEN must be at least 2");
  end

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);

  accum_state_e     state_q;
  logic [ACC_W-1:0] sum_q;
  logic [CNT_W-1:0] add_cnt_q;
  logic [CNT_W-1:0] sub_cnt_q;
  logic [CNT_W-1:0] smp_cnt_q;
  logic             ovf_q;

  // One extra bit on top of the accumulator captures the carry out.
  logic [ACC_W:0]   sum_ext;
  logic             in_hs;

  always_comb begin
    sum_ext = {1'b0, sum_q} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_data_i};
    in_hs   = in_valid_i && (state_q == ACCUM);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q   <= ACCUM;
      sum_q     <= '0;
      add_cnt_q <= '0;
      sub_cnt_q <= '0;
      smp_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_hs) begin
            sum_q     <= sum_ext[ACC_W-1:0];
            ovf_q     <= ovf_q | sum_ext[ACC_W];
            smp_cnt_q <= smp_cnt_q + 1'b1;
            if (in_add_i) add_cnt_q <= add_cnt_q + 1'b1;
            else          sub_cnt_q <= sub_cnt_q + 1'b1;
            // This accept completes the block.
            if (smp_cnt_q == LAST_IDX) state_q <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready_i) begin
            state_q   <= ACCUM;
            sum_q     <= '0;
            add_cnt_q <= '0;
            sub_cnt_q <= '0;
            smp_cnt_q <= '0;
            ovf_q     <= 1'b0;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign in_ready_o    = (state_q == ACCUM);
  assign out_valid_o   = (state_q == HOLD);
  assign out_sum_o     = sum_q;
  assign out_add_cnt_o = add_cnt_q;
  assign out_sub_cnt_o = sub_cnt_q;
  assign out_ovf_o     = ovf_q;
  assign dbg_state_o   = state_q;

endmodule : addsub_accum

// File: tb/tb_addsub_accum.sv
// tb_addsub_accum: self-checking bench for addsub_accum, configured with
// DATA_W = 4, ACC_W = 5, BLOCK_LEN = 4 so the reference, overflow and bubble
// scenarios all run on one instance. The reference model keeps the accepted
// results of the current block in a queue; the block is full (totals
// presented) when the queue holds BLOCK_LEN entries, and all expected totals
// are computed from the queue contents with plain integer arithmetic.
module tb_addsub_accum;
  import addsub_pkg::*;

  localparam int DATA_W    = 4;
  localparam int ACC_W     = 5;
  localparam int BLOCK_LEN = 4;
  localparam int CNT_W     = $clog2(BLOCK_LEN + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_add;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_add_cnt;
  logic [CNT_W-1:0]  out_sub_cnt;
  logic              out_ovf;
  accum_state_e      dbg_state;

  addsub_accum #(
    .DATA_W    (DATA_W),
    .ACC_W     (ACC_W),
    .BLOCK_LEN (BLOCK_LEN)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clear_i       (clear),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_data_i     (in_data),
    .in_add_i      (in_add),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_sum_o     (out_sum),
    .out_add_cnt_o (out_add_cnt),
    .out_sub_cnt_o (out_sub_cnt),
    .out_ovf_o     (out_ovf),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Each entry is {add_flag, data} of one accepted result of the open block.
  logic [DATA_W:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int blk_total();
    int s = 0;
    foreach (exp_q[i]) s += int'(exp_q[i][DATA_W-1:0]);
    return s;
  endfunction

  function automatic int blk_adds();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i][DATA_W]) n++;
    return n;
  endfunction

  function automatic bit blk_full();
    return exp_q.size() == BLOCK_LEN;
  endfunction

  task automatic compare_all();
    int total;
    total = blk_total();
    check("in_ready",  32'(in_ready),    32'(!blk_full()));
    check("out_valid", 32'(out_valid),   32'(blk_full()));
    check("state",     32'(dbg_state),   blk_full() ? 32'(HOLD) : 32'(ACCUM));
    check("sum",       32'(out_sum),     32'(total % (1 << ACC_W)));
    check("add_cnt",   32'(out_add_cnt), 32'(blk_adds()));
    check("sub_cnt",   32'(out_sub_cnt), 32'(exp_q.size() - blk_adds()));
    // Values only grow, so some carry happened iff the true total reached 2^ACC_W.
    check("ovf",       32'(out_ovf),     32'(total >= (1 << ACC_W)));
  endtask

  // ---------------- driver ----------------
  // Apply one cycle of inputs, advance the model by what the edge must do,
  // then sample the DUT 1 time unit after the edge.
  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic a,
                       input logic ordy, input logic clr, input logic rs);
    rst       = rs;
    clear     = clr;
    in_valid  = v;
    in_data   = d;
    in_add    = a;
    out_ready = ordy;
    if (rs || clr) begin
      exp_q.delete();
    end else if (blk_full()) begin
      if (ordy) exp_q.delete();
    end else if (v) begin
      exp_q.push_back({a, d});
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic put(input logic [DATA_W-1:0] d, input logic a);
    drive(1'b1, d, a, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic take();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_add = 1'b0; out_ready = 1'b0;

    // Reset
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_ready", 32'(in_ready), 32'd1);
    check("reset_sum",   32'(out_sum),  32'd0);
    idle(2);

    // Reference block: (6,add) (2,sub) (10,add) (4,sub) back-to-back
    put(4'd6, 1'b1);
    put(4'd2, 1'b0);
    put(4'd10, 1'b1);
    check("ref_not_valid_yet", 32'(out_valid), 32'd0);
    put(4'd4, 1'b0);
    check("ref_valid",   32'(out_valid),   32'd1);
    check("ref_ready0",  32'(in_ready),    32'd0);
    check("ref_sum",     32'(out_sum),     32'd22);
    check("ref_add_cnt", 32'(out_add_cnt), 32'd2);
    check("ref_sub_cnt", 32'(out_sub_cnt), 32'd2);
    check("ref_ovf",     32'(out_ovf),     32'd0);

    // Backpressure: 5 cycles of in_valid with out_ready low, then release
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      check("bp_hold_sum", 32'(out_sum), 32'd22);
    end
    drive(1'b1, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    check("bp_release_sum", 32'(out_sum), 32'd0);

    // Overflow: four 15s wrap the 5-bit accumulator
    for (int i = 0; i < 4; i++) put(4'd15, 1'b0);
    check("ovf_sum",  32'(out_sum), 32'd28);
    check("ovf_flag", 32'(out_ovf), 32'd1);
    check("ovf_sub",  32'(out_sub_cnt), 32'd4);
    take();
    for (int i = 0; i < 4; i++) put(4'd0, 1'b1);
    check("zero_ovf", 32'(out_ovf), 32'd0);
    check("zero_add", 32'(out_add_cnt), 32'd4);
    take();

    // Bubbles: valid 1,0,0,1,1,0,1 carrying data 1,2,3,4
    put(4'd1, 1'b1);
    idle(2);
    put(4'd2, 1'b0);
    put(4'd3, 1'b1);
    idle(1);
    put(4'd4, 1'b0);
    check("bubble_valid", 32'(out_valid), 32'd1);
    check("bubble_sum",   32'(out_sum),   32'd10);
    take();

    // Clear after 2 accepts, with a competing input in the clear cycle
    put(4'd7, 1'b1);
    put(4'd8, 1'b0);
    drive(1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    check("clear_sum", 32'(out_sum),     32'd0);
    check("clear_add", 32'(out_add_cnt), 32'd0);
    check("clear_sub", 32'(out_sub_cnt), 32'd0);
    put(4'd3, 1'b1);
    put(4'd5, 1'b1);
    put(4'd11, 1'b0);
    put(4'd1, 1'b1);
    check("post_clear_sum", 32'(out_sum), 32'd20);
    check("post_clear_add", 32'(out_add_cnt), 32'd3);

    // Reset mid-HOLD with clear and out_ready also high
    drive(1'b1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_hold_ready", 32'(in_ready), 32'd1);
    check("rst_hold_sum",   32'(out_sum),  32'd0);
    drive(1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-ACCUM
    put(4'd6, 1'b0);
    drive(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_accum_sub", 32'(out_sub_cnt), 32'd0);
    check("rst_accum_sum", 32'(out_sum),     32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 9) < 7),
            DATA_W'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 49) == 0),
            1'($urandom_range(0, 99) == 0));
    end

    // Sustained throughput: out_ready held high, a block every BLOCK_LEN+1 cycles
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < BLOCK_LEN; i++)
        drive(1'b1, DATA_W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
      check("tput_valid", 32'(out_valid), 32'd1);
      drive(1'b1, DATA_W'($urandom_range(0, 15)), 1'b1, 1'b1, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_addsub_accum
